// File: rtl/ariane_pkg.sv
// ariane_pkg: shared core types.
// Holds the scoreboard entry and exception records that travel between
// issue, the functional units and commit. It also holds the transaction-id
// width and the commit queue depth derived from it.
package ariane_pkg;

    localparam int unsigned XLEN           = 64;
    localparam int unsigned TRANS_ID_BITS  = 3;
    localparam int unsigned REG_ADDR_BITS  = 5;
    localparam int unsigned COMMIT_Q_DEPTH = 2 ** TRANS_ID_BITS;

    typedef enum logic [2:0] {
        NONE      = 3'd0,
        LOAD      = 3'd1,
        STORE     = 3'd2,
        ALU       = 3'd3,
        CTRL_FLOW = 3'd4,
        MULT      = 3'd5,
        CSR       = 3'd6
    } fu_t;

    typedef enum logic [3:0] {
        ADD    = 4'd0,
        SUB    = 4'd1,
        ANDL   = 4'd2,
        ORL    = 4'd3,
        XORL   = 4'd4,
        SLL    = 4'd5,
        SRL    = 4'd6,
        SRA    = 4'd7,
        LD     = 4'd8,
        SD     = 4'd9,
        MUL    = 4'd10,
        JALR   = 4'd11,
        CSR_RW = 4'd12
    } fu_op;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    typedef struct packed {
        logic [XLEN-1:0]          pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        fu_t                      fu;
        fu_op                     op;
        logic [REG_ADDR_BITS-1:0] rs1;
        logic [REG_ADDR_BITS-1:0] rs2;
        logic [REG_ADDR_BITS-1:0] rd;
        logic [XLEN-1:0]          result;
        logic                     valid;
        exception_t               ex;
    } scoreboard_entry_t;

endpackage

// File: rtl/commit_queue_checker.sv
// commit_queue_checker: passive protocol and consistency checks for commit_queue.
// Ports:
//   clk_i, rst_i, flush_i        - clock, async reset, flush
//   wb_valid_i, wb_trans_id_i    - writeback strobes and target slots
//   issued_r, done_r             - per-slot status of the queue
//   count_r                      - occupancy register of the queue
module commit_queue_checker import ariane_pkg::*; #(
    parameter int unsigned NR_ENTRIES  = COMMIT_Q_DEPTH,
    parameter int unsigned NR_WB_PORTS = 4
) (
    input logic                                        clk_i,
    input logic                                        rst_i,
    input logic                                        flush_i,
    input logic [NR_WB_PORTS-1:0]                      wb_valid_i,
    input logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   wb_trans_id_i,
    input logic [NR_ENTRIES-1:0]                       issued_r,
    input logic [NR_ENTRIES-1:0]                       done_r,
    input logic [$clog2(NR_ENTRIES):0]                 count_r
);

    localparam int unsigned CNT_W = $clog2(NR_ENTRIES) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(NR_ENTRIES);

    // A writeback must name a slot that holds an unfinished instruction.
    for (genvar p = 0; p < NR_WB_PORTS; p++) begin : g_wb
        wb_target_live: assert property (@(posedge clk_i) disable iff (rst_i)
            (wb_valid_i[p] && !flush_i) |->
            (issued_r[wb_trans_id_i[p]] && !done_r[wb_trans_id_i[p]]));
    end

    count_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
        count_r <= DEPTH_C);

    count_matches_issued: assert property (@(posedge clk_i) disable iff (rst_i)
        int'($countones(issued_r)) == int'(count_r));

endmodule

// File: rtl/commit_queue.sv
// commit_queue: in-order retirement buffer between issue and commit.
// Issue writes one entry per cycle at the tail; the slot index is the
// transaction id. FU writeback ports mark entries finished. The oldest
// NR_COMMIT_PORTS entries are presented to the commit stage, which retires
// them in order with per-port acknowledges.
// Ports:
//   clk_i, rst_i (async, active-high), flush_i (drop all entries)
//   issue_valid_i / issue_ready_o / issue_instr_i / issue_trans_id_o - issue side
//   wb_valid_i / wb_trans_id_i / wb_result_i / wb_ex_i                - writeback ports
//   commit_instr_o / commit_ack_i                                     - commit side
//   empty_o, usage_o                                                  - occupancy
module commit_queue import ariane_pkg::*; #(
    parameter int unsigned NR_ENTRIES      = COMMIT_Q_DEPTH,
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned NR_WB_PORTS     = 4
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      flush_i,
    input  logic                                      issue_valid_i,
    output logic                                      issue_ready_o,
    input  scoreboard_entry_t                         issue_instr_i,
    output logic [TRANS_ID_BITS-1:0]                  issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]                    wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_i,
    input  logic [NR_WB_PORTS-1:0][XLEN-1:0]          wb_result_i,
    input  exception_t [NR_WB_PORTS-1:0]              wb_ex_i,
    output scoreboard_entry_t [NR_COMMIT_PORTS-1:0]   commit_instr_o,
    input  logic [NR_COMMIT_PORTS-1:0]                commit_ack_i,
    output logic                                      empty_o,
    output logic [$clog2(NR_ENTRIES):0]               usage_o
);

    // count needs one bit more than the pointers so a full queue is representable
    localparam int unsigned CNT_W = $clog2(NR_ENTRIES) + 1;

    typedef logic [TRANS_ID_BITS-1:0] ptr_t;
    typedef logic [CNT_W-1:0]         cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(NR_ENTRIES);
    localparam cnt_t CNT_ONE = cnt_t'(1'b1);

    ptr_t                  head_r;
    ptr_t                  tail_r;
    cnt_t                  count_r;
    logic [NR_ENTRIES-1:0] issued_r;
    logic [NR_ENTRIES-1:0] done_r;
    scoreboard_entry_t     slot_r [NR_ENTRIES];

    logic                               issue_ready_s;
    logic                               issue_fire_s;
    logic [NR_COMMIT_PORTS-1:0]         commit_valid_s;
    cnt_t                               pop_s;
    logic                               gap_s;
    logic [NR_ENTRIES-1:0]              pop_mask_s;
    logic [NR_ENTRIES-1:0]              wb_hit_s;
    logic [NR_ENTRIES-1:0][XLEN-1:0]    wb_result_s;
    exception_t [NR_ENTRIES-1:0]        wb_ex_s;

    assign issue_ready_o    = issue_ready_s;
    assign issue_trans_id_o = tail_r;
    assign empty_o          = (count_r == '0);
    assign usage_o          = count_r;

    // Issue handshake; readiness depends only on the registered count.
    always_comb begin
        issue_ready_s = (count_r != DEPTH_C);
        issue_fire_s  = issue_valid_i && issue_ready_s;
    end

    // Commit view: the oldest slots with trans_id forced to their slot index.
    always_comb begin
        commit_instr_o = '0;
        commit_valid_s = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            commit_valid_s[i] = issued_r[head_r + ptr_t'(i)] && done_r[head_r + ptr_t'(i)]
                                && (cnt_t'(i) < count_r);
            commit_instr_o[i]          = slot_r[head_r + ptr_t'(i)];
            commit_instr_o[i].trans_id = head_r + ptr_t'(i);
            commit_instr_o[i].valid    = commit_valid_s[i];
        end
    end

    // Pop count: leading acknowledged-and-valid ports from port 0; the first gap
    // stops retirement so later acks can never overtake an older entry.
    always_comb begin
        pop_s      = '0;
        gap_s      = 1'b0;
        pop_mask_s = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (!gap_s && commit_ack_i[i] && commit_valid_s[i]) begin
                pop_s = pop_s + CNT_ONE;
                pop_mask_s[head_r + ptr_t'(i)] = 1'b1;
            end else begin
                gap_s = 1'b1;
            end
        end
    end

    // Writeback match per slot; ports scanned high to low so the lowest index wins.
    always_comb begin
        wb_hit_s    = '0;
        wb_result_s = '0;
        wb_ex_s     = '0;
        for (int s = 0; s < NR_ENTRIES; s++) begin
            for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
                if (wb_valid_i[p] && (wb_trans_id_i[p] == ptr_t'(s)) && issued_r[s] && !done_r[s]) begin
                    wb_hit_s[s]    = 1'b1;
                    wb_result_s[s] = wb_result_i[p];
                    wb_ex_s[s]     = wb_ex_i[p];
                end else begin
                    wb_hit_s[s] = wb_hit_s[s];
                end
            end
        end
    end

    // Slot contents, status bits and pointers. Pop, writeback and issue always
    // touch disjoint slots: popped slots are done, writeback needs not-done,
    // and the tail slot is never issued while the queue has room.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_r   <= '0;
            tail_r   <= '0;
            count_r  <= '0;
            issued_r <= '0;
            done_r   <= '0;
            for (int s = 0; s < NR_ENTRIES; s++) begin
                slot_r[s] <= '0;
            end
        end else if (flush_i) begin
            head_r   <= '0;
            tail_r   <= '0;
            count_r  <= '0;
            issued_r <= '0;
            done_r   <= '0;
        end else begin
            for (int s = 0; s < NR_ENTRIES; s++) begin
                if (pop_mask_s[s]) begin
                    issued_r[s] <= 1'b0;
                    done_r[s]   <= 1'b0;
                end else if (wb_hit_s[s]) begin
                    done_r[s]        <= 1'b1;
                    slot_r[s].result <= wb_result_s[s];
                    // a clean writeback keeps whatever exception issue recorded
                    if (wb_ex_s[s].valid) begin
                        slot_r[s].ex <= wb_ex_s[s];
                    end else begin
                        slot_r[s].ex <= slot_r[s].ex;
                    end
                end else if (issue_fire_s && (tail_r == ptr_t'(s))) begin
                    slot_r[s]   <= issue_instr_i;
                    issued_r[s] <= 1'b1;
                    // a decode exception needs no FU, so the entry is finished at once
                    done_r[s]   <= issue_instr_i.ex.valid;
                end else begin
                    done_r[s] <= done_r[s];
                end
            end
            head_r  <= head_r + pop_s[TRANS_ID_BITS-1:0];
            tail_r  <= tail_r + ptr_t'(issue_fire_s);
            count_r <= count_r + cnt_t'(issue_fire_s) - pop_s;
        end
    end

    commit_queue_checker #(
        .NR_ENTRIES  (NR_ENTRIES),
        .NR_WB_PORTS (NR_WB_PORTS)
    ) u_checker (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .wb_valid_i    (wb_valid_i),
        .wb_trans_id_i (wb_trans_id_i),
        .issued_r      (issued_r),
        .done_r        (done_r),
        .count_r       (count_r)
    );

endmodule

// File: tb/tb_commit_queue.sv
// tb_commit_queue: directed and random stimulus for commit_queue, checked
// against an in-order queue model of the retirement buffer.
module tb_commit_queue;
    import ariane_pkg::*;

    localparam int NR_ENTRIES      = 8;
    localparam int NR_COMMIT_PORTS = 2;
    localparam int NR_WB_PORTS     = 4;

    logic                                      clk_i = 1'b0;
    logic                                      rst_i;
    logic                                      flush_i;
    logic                                      issue_valid_i;
    logic                                      issue_ready_o;
    scoreboard_entry_t                         issue_instr_i;
    logic [TRANS_ID_BITS-1:0]                  issue_trans_id_o;
    logic [NR_WB_PORTS-1:0]                    wb_valid_i;
    logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_i;
    logic [NR_WB_PORTS-1:0][XLEN-1:0]          wb_result_i;
    exception_t [NR_WB_PORTS-1:0]              wb_ex_i;
    scoreboard_entry_t [NR_COMMIT_PORTS-1:0]   commit_instr_o;
    logic [NR_COMMIT_PORTS-1:0]                commit_ack_i;
    logic                                      empty_o;
    logic [3:0]                                usage_o;

    commit_queue #(
        .NR_ENTRIES      (NR_ENTRIES),
        .NR_COMMIT_PORTS (NR_COMMIT_PORTS),
        .NR_WB_PORTS     (NR_WB_PORTS)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .issue_valid_i    (issue_valid_i),
        .issue_ready_o    (issue_ready_o),
        .issue_instr_i    (issue_instr_i),
        .issue_trans_id_o (issue_trans_id_o),
        .wb_valid_i       (wb_valid_i),
        .wb_trans_id_i    (wb_trans_id_i),
        .wb_result_i      (wb_result_i),
        .wb_ex_i          (wb_ex_i),
        .commit_instr_o   (commit_instr_o),
        .commit_ack_i     (commit_ack_i),
        .empty_o          (empty_o),
        .usage_o          (usage_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: program-ordered list of in-flight instructions.
    typedef struct {
        int                id;
        scoreboard_entry_t e;
        bit                done;
    } mrec_t;

    mrec_t mq[$];
    int    next_id;
    int    pend[$];
    int    n_checks;
    int    n_fail;

    task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exception_t make_ex(input bit v);
        exception_t x;
        x       = '0;
        x.valid = v;
        if (v) begin
            x.cause = 64'($urandom_range(0, 15));
            x.tval  = {$urandom, $urandom};
        end
        return x;
    endfunction

    function automatic scoreboard_entry_t make_instr(input bit ex_v, input bit rand_fu);
        scoreboard_entry_t e;
        e     = '0;
        e.pc  = {$urandom, $urandom};
        e.fu  = rand_fu ? fu_t'($urandom_range(0, 6)) : ALU;
        e.op  = fu_op'($urandom_range(0, 12));
        e.rs1 = 5'($urandom);
        e.rs2 = 5'($urandom);
        e.rd  = 5'($urandom);
        e.ex  = make_ex(ex_v);
        return e;
    endfunction

    task automatic drive_idle();
        flush_i       = 1'b0;
        issue_valid_i = 1'b0;
        issue_instr_i = '0;
        wb_valid_i    = '0;
        wb_trans_id_i = '0;
        wb_result_i   = '0;
        wb_ex_i       = '0;
        commit_ack_i  = '0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_next();
        int    pop;
        bit    gap;
        bit    fire;
        bit    found;
        mrec_t r;
        fire = issue_valid_i && (mq.size() != NR_ENTRIES);
        if (flush_i) begin
            mq.delete();
            next_id = 0;
        end else begin
            pop = 0;
            gap = 0;
            for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
                if (!gap && commit_ack_i[i] && i < mq.size() && mq[i].done) pop++;
                else gap = 1;
            end
            for (int s = 0; s < mq.size(); s++) begin
                found = 0;
                for (int p = 0; p < NR_WB_PORTS; p++) begin
                    if (!found && !mq[s].done && wb_valid_i[p] && int'(wb_trans_id_i[p]) == mq[s].id) begin
                        found = 1;
                        mq[s].e.result = wb_result_i[p];
                        if (wb_ex_i[p].valid) mq[s].e.ex = wb_ex_i[p];
                    end
                end
                if (found) mq[s].done = 1;
            end
            for (int k = 0; k < pop; k++) void'(mq.pop_front());
            if (fire) begin
                r.id         = next_id;
                r.e          = issue_instr_i;
                r.e.trans_id = TRANS_ID_BITS'(next_id);
                r.done       = issue_instr_i.ex.valid;
                mq.push_back(r);
                next_id = (next_id + 1) % NR_ENTRIES;
            end
        end
    endtask

    task automatic compare_all();
        int                head;
        bit                exp_v;
        scoreboard_entry_t exp_e;
        head = (next_id - mq.size() + NR_ENTRIES) % NR_ENTRIES;
        check_val("usage", 512'(usage_o), 512'(mq.size()));
        check_val("empty", 512'(empty_o), 512'(mq.size() == 0));
        check_val("ready", 512'(issue_ready_o), 512'(mq.size() != NR_ENTRIES));
        check_val("issue_tid", 512'(issue_trans_id_o), 512'(next_id));
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            exp_v = 0;
            if (i < mq.size()) exp_v = mq[i].done;
            check_val($sformatf("cvalid%0d", i), 512'(commit_instr_o[i].valid), 512'(exp_v));
            check_val($sformatf("ctid%0d", i), 512'(commit_instr_o[i].trans_id), 512'((head + i) % NR_ENTRIES));
            if (exp_v) begin
                exp_e          = mq[i].e;
                exp_e.valid    = 1'b1;
                exp_e.trans_id = TRANS_ID_BITS'(mq[i].id);
                check_val($sformatf("centry%0d", i), 512'(commit_instr_o[i]), 512'(exp_e));
            end
        end
    endtask

    task automatic cycle();
        model_next();
        @(posedge clk_i);
        @(negedge clk_i);
        compare_all();
        drive_idle();
    endtask

    task automatic flush_cycle();
        flush_i = 1'b1;
        cycle();
    endtask

    logic [XLEN-1:0] res_a;
    exception_t      ex_a;
    logic [XLEN-1:0] cause_a;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        next_id  = 0;
        drive_idle();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        compare_all();

        // three ALU ops, no writeback
        for (int k = 0; k < 3; k++) begin
            check_val("issue_seq_tid", 512'(issue_trans_id_o), 512'(k));
            issue_valid_i = 1'b1;
            issue_instr_i = make_instr(1'b0, 1'b0);
            cycle();
        end
        check_val("usage3", 512'(usage_o), 512'(3));
        check_val("c0_not_done", 512'(commit_instr_o[0].valid), 512'(0));
        check_val("c1_not_done", 512'(commit_instr_o[1].valid), 512'(0));

        // slot 1 finishes first, then slot 0
        wb_valid_i[0] = 1'b1; wb_trans_id_i[0] = 3'd1; wb_result_i[0] = {$urandom, $urandom};
        cycle();
        check_val("c0_waits_slot0", 512'(commit_instr_o[0].valid), 512'(0));
        wb_valid_i[2] = 1'b1; wb_trans_id_i[2] = 3'd0; wb_result_i[2] = {$urandom, $urandom};
        cycle();
        check_val("c0_valid", 512'(commit_instr_o[0].valid), 512'(1));
        check_val("c1_valid", 512'(commit_instr_o[1].valid), 512'(1));
        commit_ack_i = 2'b11;
        cycle();
        check_val("usage_after_ack2", 512'(usage_o), 512'(1));
        check_val("head_after_ack2", 512'(commit_instr_o[0].trans_id), 512'(2));

        // fill to full, ack one with issue offered, then wrap to slot 0
        flush_cycle();
        for (int k = 0; k < 8; k++) begin
            issue_valid_i = 1'b1;
            issue_instr_i = make_instr(1'b0, 1'b1);
            cycle();
        end
        check_val("full_ready", 512'(issue_ready_o), 512'(0));
        check_val("full_usage", 512'(usage_o), 512'(8));
        wb_valid_i[1] = 1'b1; wb_trans_id_i[1] = 3'd0; wb_result_i[1] = {$urandom, $urandom};
        cycle();
        commit_ack_i  = 2'b01;
        issue_valid_i = 1'b1;
        issue_instr_i = make_instr(1'b0, 1'b1);
        cycle();
        check_val("full_ack_no_issue", 512'(usage_o), 512'(7));
        check_val("wrap_tid", 512'(issue_trans_id_o), 512'(0));
        issue_valid_i = 1'b1;
        issue_instr_i = make_instr(1'b0, 1'b1);
        cycle();
        check_val("wrap_usage", 512'(usage_o), 512'(8));

        // same slot on two ports: port 0 wins; then an ack with a gap at port 0
        res_a = {$urandom, $urandom};
        wb_valid_i[0] = 1'b1; wb_trans_id_i[0] = 3'd1; wb_result_i[0] = res_a;
        wb_valid_i[3] = 1'b1; wb_trans_id_i[3] = 3'd1; wb_result_i[3] = ~res_a;
        wb_valid_i[1] = 1'b1; wb_trans_id_i[1] = 3'd2; wb_result_i[1] = {$urandom, $urandom};
        cycle();
        check_val("wb_low_port_wins", 512'(commit_instr_o[0].result), 512'(res_a));
        commit_ack_i = 2'b10;
        cycle();
        check_val("gap_ack_usage", 512'(usage_o), 512'(8));
        check_val("gap_ack_head", 512'(commit_instr_o[0].trans_id), 512'(1));
        commit_ack_i = 2'b11;
        cycle();

        // decode exception finishes at issue; FU exception replaces issued ex
        flush_cycle();
        issue_valid_i = 1'b1;
        issue_instr_i = make_instr(1'b1, 1'b1);
        cause_a       = issue_instr_i.ex.cause;
        cycle();
        check_val("decode_ex_valid", 512'(commit_instr_o[0].valid), 512'(1));
        check_val("decode_ex_cause", 512'(commit_instr_o[0].ex.cause), 512'(cause_a));
        issue_valid_i = 1'b1;
        issue_instr_i = make_instr(1'b0, 1'b1);
        cycle();
        ex_a = make_ex(1'b1);
        wb_valid_i[3] = 1'b1; wb_trans_id_i[3] = 3'd1; wb_ex_i[3] = ex_a;
        cycle();
        check_val("wb_ex_valid", 512'(commit_instr_o[1].valid), 512'(1));
        check_val("wb_ex_replaced", 512'(commit_instr_o[1].ex), 512'(ex_a));

        // flush with five entries and simultaneous activity
        flush_cycle();
        for (int k = 0; k < 5; k++) begin
            issue_valid_i = 1'b1;
            issue_instr_i = make_instr(1'b0, 1'b1);
            cycle();
        end
        flush_i       = 1'b1;
        issue_valid_i = 1'b1;
        issue_instr_i = make_instr(1'b0, 1'b1);
        wb_valid_i[0] = 1'b1; wb_trans_id_i[0] = 3'd3;
        commit_ack_i  = 2'b11;
        cycle();
        check_val("flush_usage", 512'(usage_o), 512'(0));
        check_val("flush_empty", 512'(empty_o), 512'(1));
        check_val("flush_tail", 512'(issue_trans_id_o), 512'(0));

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            flush_i       = ($urandom_range(0, 99) < 2);
            issue_valid_i = ($urandom_range(0, 99) < 60);
            issue_instr_i = make_instr($urandom_range(0, 9) == 0, 1'b1);
            pend.delete();
            foreach (mq[k]) if (!mq[k].done) pend.push_back(mq[k].id);
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                if (pend.size() > 0 && $urandom_range(0, 99) < 35) begin
                    wb_valid_i[p]    = 1'b1;
                    wb_trans_id_i[p] = TRANS_ID_BITS'(pend[$urandom_range(0, pend.size() - 1)]);
                    wb_result_i[p]   = {$urandom, $urandom};
                    wb_ex_i[p]       = make_ex($urandom_range(0, 6) == 0);
                end
            end
            commit_ack_i = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'($urandom_range(0, 3));
            cycle();
        end

        // asynchronous reset in the middle of traffic
        flush_cycle();
        for (int k = 0; k < 4; k++) begin
            issue_valid_i = 1'b1;
            issue_instr_i = make_instr(k == 0, 1'b1);
            cycle();
        end
        #2;
        rst_i = 1'b1;
        mq.delete();
        next_id = 0;
        #1;
        check_val("arst_usage", 512'(usage_o), 512'(0));
        check_val("arst_empty", 512'(empty_o), 512'(1));
        check_val("arst_ready", 512'(issue_ready_o), 512'(1));
        check_val("arst_c0", 512'(commit_instr_o[0].valid), 512'(0));
        check_val("arst_tail", 512'(issue_trans_id_o), 512'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        compare_all();
        for (int k = 0; k < 3; k++) begin
            issue_valid_i = 1'b1;
            issue_instr_i = make_instr(1'b1, 1'b1);
            cycle();
        end
        commit_ack_i = 2'b11;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
